// File: rtl/cpu_pipe_pkg.sv
// rtl/cpu_pipe_pkg.sv - shared types and per-stage widths for the CPU pipeline registers
package cpu_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HEAD  = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  localparam int IF_ID_DATA_W  = 64;
  localparam int IF_ID_CTRL_W  = 1;
  localparam int ID_EX_DATA_W  = 128;
  localparam int ID_EX_CTRL_W  = 8;
  localparam int EX_MEM_DATA_W = 74;
  localparam int EX_MEM_CTRL_W = 5;
  localparam int MEM_WB_DATA_W = 69;
  localparam int MEM_WB_CTRL_W = 2;

  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_TO_REG = 1;
  localparam int CTRL_MEM_READ   = 2;
  localparam int CTRL_MEM_WRITE  = 3;
  localparam int CTRL_BRANCH     = 4;
  localparam int CTRL_JUMP       = 5;
  localparam int CTRL_ALU_SRC    = 6;

  function automatic logic [1:0] state_occ(input pipe_state_e s);
    case (s)
      ST_HEAD: return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// rtl/pipe_entry.sv - one storage slot (valid, data, ctrl) of a pipeline stage register
module pipe_entry
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_drop,
  input  logic              i_clear_ctrl,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;

  // Squash wins over load so a same-cycle input never survives a flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= RESET_DATA;
      r_ctrl  <= '0;
    end else if (i_clear_ctrl) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_ctrl  <= i_ctrl;
    end else if (i_drop) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register with handshake, stall, flush and optional skid slot
module pipe_stage_reg
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  localparam logic [1:0] MAX_OCC = 2'(1 + SKID);

  pipe_state_e       r_state, w_next_state;
  logic              r_in_ready;
  logic              w_in_xfer, w_out_xfer;
  logic              w_main_load, w_main_drop, w_skid_load, w_skid_drop, w_main_from_skid;
  logic              w_main_valid, w_skid_valid;
  logic [DATA_W-1:0] w_main_data, w_skid_data, w_main_in_data;
  logic [CTRL_W-1:0] w_main_ctrl, w_skid_ctrl, w_main_in_ctrl;

  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state != ST_FULL);
    end
  end

  always_comb begin
    w_next_state     = r_state;
    w_main_load      = 1'b0;
    w_main_drop      = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_drop      = 1'b0;
    w_main_from_skid = 1'b0;
    if (flush) begin
      w_next_state = ST_EMPTY;
    end else if (!stall) begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            w_next_state = ST_HEAD;
            w_main_load  = 1'b1;
          end
        end
        ST_HEAD: begin
          if (w_in_xfer && w_out_xfer) begin
            w_main_load = 1'b1;
          end else if (w_in_xfer) begin
            if (SKID != 0) begin
              w_next_state = ST_FULL;
              w_skid_load  = 1'b1;
            end else begin
              w_main_load = 1'b1;
            end
          end else if (w_out_xfer) begin
            w_next_state = ST_EMPTY;
            w_main_drop  = 1'b1;
          end
        end
        ST_FULL: begin
          if (w_out_xfer) begin
            w_next_state     = ST_HEAD;
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
            w_skid_drop      = 1'b1;
          end
        end
        default: w_next_state = ST_EMPTY;
      endcase
    end
  end

  assign w_main_in_data = w_main_from_skid ? w_skid_data : in_data;
  assign w_main_in_ctrl = w_main_from_skid ? w_skid_ctrl : in_ctrl;

  pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .RESET_DATA(RESET_DATA)) u_main (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_main_load),
    .i_drop       (w_main_drop),
    .i_clear_ctrl (flush),
    .i_data       (w_main_in_data),
    .i_ctrl       (w_main_in_ctrl),
    .o_valid      (w_main_valid),
    .o_data       (w_main_data),
    .o_ctrl       (w_main_ctrl)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .RESET_DATA(RESET_DATA)) u_skid (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_skid_load),
        .i_drop       (w_skid_drop),
        .i_clear_ctrl (flush),
        .i_data       (in_data),
        .i_ctrl       (in_ctrl),
        .o_valid      (w_skid_valid),
        .o_data       (w_skid_data),
        .o_ctrl       (w_skid_ctrl)
      );
      assign in_ready = r_in_ready & ~stall;
    end else begin : g_noskid
      assign w_skid_valid = 1'b0;
      assign w_skid_data  = '0;
      assign w_skid_ctrl  = '0;
      // Single slot: accept when empty or when the head leaves this same edge.
      assign in_ready = reset & ~stall & ((r_state == ST_EMPTY) | out_ready);
    end
  endgenerate

  assign out_valid = w_main_valid & ~stall;
  assign out_data  = w_main_data;
  assign out_ctrl  = w_main_ctrl & {CTRL_W{out_valid}};
  assign occupancy = state_occ(r_state);

  a_occ_max: assert property (@(posedge clk) disable iff (!reset) occupancy <= MAX_OCC);
  a_no_in_full: assert property (@(posedge clk) disable iff (!reset)
    !(r_state == ST_FULL && w_in_xfer));
  a_skid_state: assert property (@(posedge clk) disable iff (!reset)
    w_skid_valid == (r_state == ST_FULL));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg, skid and single-slot builds
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid1, in_ready1, stall1, flush1, out_valid1, out_ready1;
  logic [31:0] in_data1, out_data1;
  logic [7:0]  in_ctrl1, out_ctrl1;
  logic [1:0]  occ1;
  logic        in_valid0, in_ready0, stall0, flush0, out_valid0, out_ready0;
  logic [31:0] in_data0, out_data0;
  logic [7:0]  in_ctrl0, out_ctrl0;
  logic [1:0]  occ0;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(1), .RESET_DATA(32'hDEAD_BEEF)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .in_ctrl(in_ctrl1), .stall(stall1), .flush(flush1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .out_ctrl(out_ctrl1), .occupancy(occ1)
  );

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(0), .RESET_DATA(32'h0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_data(in_data0), .in_ctrl(in_ctrl0), .stall(stall0), .flush(flush0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .out_ctrl(out_ctrl0), .occupancy(occ0)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  logic [39:0] q1[$];
  logic [39:0] q0[$];

  always @(negedge reset) begin
    q1.delete();
    q0.delete();
  end

  always @(negedge clk) begin
    logic [39:0] e;
    if (reset) begin
      if (flush1) q1.delete();
      else begin
        if (out_valid1 && out_ready1) begin
          if (q1.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sb1_empty: got data %h with nothing expected", out_data1);
          end else begin
            e = q1.pop_front();
            chk("sb1_data", out_data1, e[39:8]);
            chk("sb1_ctrl", {24'h0, out_ctrl1}, {24'h0, e[7:0]});
          end
        end
        if (in_valid1 && in_ready1) q1.push_back({in_data1, in_ctrl1});
      end
      if (flush0) q0.delete();
      else begin
        if (out_valid0 && out_ready0) begin
          if (q0.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sb0_empty: got data %h with nothing expected", out_data0);
          end else begin
            e = q0.pop_front();
            chk("sb0_data", out_data0, e[39:8]);
            chk("sb0_ctrl", {24'h0, out_ctrl0}, {24'h0, e[7:0]});
          end
        end
        if (in_valid0 && in_ready0) q0.push_back({in_data0, in_ctrl0});
      end
    end
  end

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic [7:0]  c;
    logic        ordy, stl, fl;
    logic        e_ov, e_ir;
    logic [1:0]  e_occ;
    logic [31:0] e_od;
    logic [7:0]  e_oc;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic [31:0] d, input logic [7:0] c,
                              input logic ordy, input logic stl, input logic fl,
                              input logic e_ov, input logic e_ir, input logic [1:0] e_occ,
                              input logic [31:0] e_od, input logic [7:0] e_oc);
    vec_t v;
    v.iv = iv; v.d = d; v.c = c; v.ordy = ordy; v.stl = stl; v.fl = fl;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_occ = e_occ; v.e_od = e_od; v.e_oc = e_oc;
    return v;
  endfunction

  vec_t tbl[20];

  initial begin
    // backpressure into the skid slot, then drain
    tbl[0]  = mk(1, 32'hA,  8'h8A, 0, 0, 0,  0, 1, 0, 32'h0,  8'h00);
    tbl[1]  = mk(1, 32'hB,  8'h8B, 0, 0, 0,  1, 1, 1, 32'hA,  8'h8A);
    tbl[2]  = mk(0, 32'h0,  8'h00, 0, 0, 0,  1, 0, 2, 32'hA,  8'h8A);
    tbl[3]  = mk(1, 32'hC,  8'h8C, 0, 0, 0,  1, 0, 2, 32'hA,  8'h8A);
    tbl[4]  = mk(0, 32'h0,  8'h00, 1, 0, 0,  1, 0, 2, 32'hA,  8'h8A);
    tbl[5]  = mk(0, 32'h0,  8'h00, 1, 0, 0,  1, 1, 1, 32'hB,  8'h8B);
    tbl[6]  = mk(0, 32'h0,  8'h00, 1, 0, 0,  0, 1, 0, 32'h0,  8'h00);
    // stall holding ctrl 0x3C
    tbl[7]  = mk(1, 32'h77, 8'h3C, 0, 0, 0,  0, 1, 0, 32'h0,  8'h00);
    tbl[8]  = mk(0, 32'h0,  8'h00, 1, 1, 0,  0, 0, 1, 32'h0,  8'h00);
    tbl[9]  = mk(1, 32'h99, 8'h99, 1, 1, 0,  0, 0, 1, 32'h0,  8'h00);
    tbl[10] = mk(0, 32'h0,  8'h00, 0, 0, 0,  1, 1, 1, 32'h77, 8'h3C);
    // flush while full with a pending input
    tbl[11] = mk(1, 32'h44, 8'h44, 0, 0, 0,  1, 1, 1, 32'h77, 8'h3C);
    tbl[12] = mk(1, 32'h55, 8'h55, 0, 0, 1,  1, 0, 2, 32'h77, 8'h3C);
    tbl[13] = mk(0, 32'h0,  8'h00, 1, 0, 0,  0, 1, 0, 32'h0,  8'h00);
    // flush with an accepted input and an out handshake in the same cycle
    tbl[14] = mk(1, 32'h12, 8'h12, 0, 0, 0,  0, 1, 0, 32'h0,  8'h00);
    tbl[15] = mk(1, 32'h55, 8'h55, 1, 0, 1,  1, 1, 1, 32'h12, 8'h12);
    tbl[16] = mk(0, 32'h0,  8'h00, 1, 0, 0,  0, 1, 0, 32'h0,  8'h00);
    // flush overrides stall
    tbl[17] = mk(1, 32'h21, 8'h21, 0, 0, 0,  0, 1, 0, 32'h0,  8'h00);
    tbl[18] = mk(0, 32'h0,  8'h00, 0, 1, 1,  0, 0, 1, 32'h0,  8'h00);
    tbl[19] = mk(0, 32'h0,  8'h00, 1, 0, 0,  0, 1, 0, 32'h0,  8'h00);

    in_valid1 = 1; in_data1 = 32'h5; in_ctrl1 = 8'hFF; stall1 = 0; flush1 = 0; out_ready1 = 1;
    in_valid0 = 1; in_data0 = 32'h5; in_ctrl0 = 8'hFF; stall0 = 0; flush0 = 0; out_ready0 = 1;
    #2 reset = 1'b0;

    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst1_ov", out_valid1, 0);
      chk("rst1_oc", out_ctrl1, 0);
      chk("rst1_occ", occ1, 0);
      chk("rst1_ir", in_ready1, 0);
      chk("rst1_od", out_data1, 32'hDEAD_BEEF);
      chk("rst0_ov", out_valid0, 0);
      chk("rst0_ir", in_ready0, 0);
      chk("rst0_occ", occ0, 0);
    end
    @(posedge clk); #1;
    reset = 1'b1; in_valid1 = 0; in_valid0 = 0;
    @(negedge clk);
    chk("rel1_ir_before_edge", in_ready1, 0);
    chk("rel0_ir_comb", in_ready0, 1);
    @(negedge clk);
    chk("rel1_ir_after_edge", in_ready1, 1);
    @(posedge clk); #1;

    for (int i = 0; i <= 8; i++) begin
      in_valid1 = (i < 8); in_data1 = 32'(i + 1); in_ctrl1 = 8'(8'h81 + i); out_ready1 = 1;
      @(negedge clk);
      chk($sformatf("str1_ir%0d", i), in_ready1, 1);
      if (i > 0) begin
        chk($sformatf("str1_ov%0d", i), out_valid1, 1);
        chk($sformatf("str1_od%0d", i), out_data1, 32'(i));
        chk($sformatf("str1_oc%0d", i), out_ctrl1, 32'(8'(8'h80 + i)));
        chk($sformatf("str1_occ%0d", i), occ1, 1);
      end else begin
        chk("str1_occ0", occ1, 0);
      end
      @(posedge clk); #1;
    end

    for (int r = 0; r < 20; r++) begin
      in_valid1 = tbl[r].iv; in_data1 = tbl[r].d; in_ctrl1 = tbl[r].c;
      out_ready1 = tbl[r].ordy; stall1 = tbl[r].stl; flush1 = tbl[r].fl;
      @(negedge clk);
      chk($sformatf("row%0d_ov", r), out_valid1, tbl[r].e_ov);
      chk($sformatf("row%0d_ir", r), in_ready1, tbl[r].e_ir);
      chk($sformatf("row%0d_occ", r), occ1, tbl[r].e_occ);
      chk($sformatf("row%0d_oc", r), out_ctrl1, tbl[r].e_oc);
      if (tbl[r].e_ov) chk($sformatf("row%0d_od", r), out_data1, tbl[r].e_od);
      @(posedge clk); #1;
    end
    in_valid1 = 0; stall1 = 0; flush1 = 0; out_ready1 = 1;

    for (int i = 0; i < 8; i++) begin
      in_valid0 = 1; in_data0 = 32'(i + 1); in_ctrl0 = 8'(8'h81 + i); out_ready0 = 1;
      @(negedge clk);
      chk($sformatf("str0_ir%0d", i), in_ready0, 1);
      if (i > 0) begin
        chk($sformatf("str0_ov%0d", i), out_valid0, 1);
        chk($sformatf("str0_od%0d", i), out_data0, 32'(i));
        chk($sformatf("str0_occ%0d", i), occ0, 1);
      end
      @(posedge clk); #1;
    end
    in_valid0 = 0; out_ready0 = 0;
    @(negedge clk);
    chk("full0_ov", out_valid0, 1);
    chk("full0_od", out_data0, 32'h8);
    chk("full0_ir_blocked", in_ready0, 0);
    #1 out_ready0 = 1;
    #1 chk("full0_ir_follows_ordy", in_ready0, 1);
    out_ready0 = 0;
    #1 reset = 1'b0;
    #1;
    chk("arst0_ov", out_valid0, 0);
    chk("arst0_oc", out_ctrl0, 0);
    chk("arst0_occ", occ0, 0);
    chk("arst0_ir", in_ready0, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("post_arst0_ov", out_valid0, 0);
    chk("post_arst0_ir", in_ready0, 1);
    @(posedge clk); #1;

    chk("q1_left", q1.size(), 0);
    chk("q0_left", q0.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline-stage register for the CPU datapath (IF/ID, ID/EX, EX/MEM, MEM/WB). It replaces the per-stage fixed registers with one block.
- Payload is split into a data field and a control field; on flush the control field is zeroed to form a bubble.
- Adds a valid/ready handshake, stall (hold), flush (squash) and an optional 2-entry skid buffer so in_ready can be driven from a flop.

Parameters:
DATA_W, 32, width of datapath payload (operands, PC, immediates, register indices packed by the instantiating stage)
CTRL_W, 8, width of control payload (RegWrite, MemRead, MemWrite, Branch, Jump, ...); forced to zero in bubbles
SKID, 1, 0 = single entry with combinational in_ready; 1 = two entries with registered in_ready
RESET_DATA, 0, value loaded into data storage on reset

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low; asserting clears all state immediately, deassertion synchronous to clk by the system
in_valid  in  1  upstream presents an entry
in_ready  out  1  stage can accept an entry this cycle
in_data  in  DATA_W  upstream data payload
in_ctrl  in  CTRL_W  upstream control payload
stall  in  1  hazard hold: no transfer in or out, contents kept
flush  in  1  squash: discard stored entries and any same-cycle input
out_valid  out  1  stage presents an entry downstream
out_ready  in  1  downstream accepts
out_data  out  DATA_W  head data
out_ctrl  out  CTRL_W  head control; all zero whenever out_valid=0
occupancy  out  2  number of stored entries (0..1 when SKID=0, 0..2 when SKID=1)

Behaviour:
- Transfer in: in_valid & in_ready at the rising edge. Transfer out: out_valid & out_ready at the rising edge.
- Reset (reset=0):
  - All entries invalid; occupancy=0; out_valid=0; out_ctrl=0; out_data=RESET_DATA.
  - in_ready=0 while reset is asserted. It becomes 1 on the first edge after deassertion, or combinationally for SKID=0.
  - Reset during an in-flight transfer drops the entry.
- States (SKID=1):
  - EMPTY: occupancy 0.
  - HEAD: main entry valid.
  - FULL: main and skid entries valid.
- Transitions (SKID=1), with stall=0 and flush=0:
  - EMPTY: in xfer -> HEAD.
  - HEAD: in xfer with no out xfer -> FULL, data goes to skid; in xfer and out xfer -> HEAD with new main; out xfer only -> EMPTY.
  - FULL: out xfer -> HEAD, skid moves to main. No input is accepted while FULL.
- in_ready:
  - SKID=1: registered; equals (next state != FULL) & !stall_next. The stall contribution is combinational; in_ready = in_ready_q & ~stall.
  - SKID=0: in_ready = ~stall & (occupancy==0 | out_ready).
- SKID=0 has states EMPTY and HEAD only. Pass-through on simultaneous in and out transfer.
- Latency: an entry accepted into EMPTY appears on out_* the next cycle. FIFO order is preserved; no reordering.
- stall=1:
  - out_valid forced 0 and in_ready forced 0; no transfers; state, data and ctrl held.
  - out_ctrl reads zero while stalled, which presents a bubble downstream.
- flush=1:
  - Highest priority, over stall and over any handshake in the same cycle.
  - On the next edge: all entries invalid, occupancy=0, stored ctrl cleared to 0, data retained (don't-care).
  - A same-cycle input handshake completes if in_ready=1, but the entry is dropped.
  - out_valid stays visible during the flush cycle, but downstream must treat an out transfer in that cycle as a flushed entry.
- out_ctrl = main_ctrl & {CTRL_W{out_valid}}. out_data = main_data regardless of valid.
- Held outputs: while out_valid=1 & out_ready=0 & flush=0, out_data and out_ctrl stay stable.
- Assertions (simulation only):
  - occupancy never exceeds 1+SKID.
  - No in transfer while FULL.

Decomposition:
- Shared package cpu_pipe_pkg:
  - state enum (ST_EMPTY, ST_HEAD, ST_FULL);
  - per-stage CTRL_W/DATA_W constants (IF_ID_*, ID_EX_*, EX_MEM_*, MEM_WB_*);
  - control-bit index constants.
- Sub-module pipe_entry: one storage slot (valid, data, ctrl) with load, clear_ctrl and async clear. Instantiated once when SKID=0 and twice when SKID=1.

Test Plan:
- Reset: hold reset=0 for 3 cycles with in_valid=1 -> out_valid=0, out_ctrl=0, occupancy=0, in_ready=0. After release, in_ready=1 the next cycle.
- Streaming, SKID=1, out_ready=1: send data 0x1..0x8, ctrl 0x81..0x88 back-to-back -> each appears 1 cycle later in order; occupancy stays 1; in_ready stays 1.
- Backpressure: out_ready=0 after sending 0xA, 0xB -> occupancy=2, in_ready=0, out_data holds 0xA. Raise out_ready -> 0xA then 0xB drain; in_ready returns 1 one cycle after the first drain.
- Stall: occupancy=1 holding ctrl 0x3C, stall=1 for 2 cycles -> out_valid=0, out_ctrl=0, in_ready=0, occupancy=1. Release -> out_ctrl=0x3C, out_valid=1.
- Flush + input: occupancy=2, flush=1 with in_valid=1 data 0x55 -> next cycle occupancy=0, out_valid=0, out_ctrl=0; 0x55 never emitted.
- SKID=0 build: same streaming test -> one-cycle latency, in_ready follows out_ready combinationally when full. Async reset asserted mid-cycle -> out_valid falls before the next edge.
